// File: rtl/mig_burst_if.sv
// Bridges a request queue and write/read data queues onto the MIG app interface,
// issuing one request at a time as a burst of single-word commands.
module mig_burst_if #(
  parameter int DW        = 128,
  parameter int AW        = 28,
  parameter int LW        = 4,
  parameter int ADDR_STEP = 8,
  parameter int CW        = 5
) (
  input  logic            mclk,
  input  logic            mrst,
  output logic [AW-1:0]   app_addr,
  output logic [2:0]      app_cmd,
  output logic            app_en,
  input  logic            app_rdy,
  output logic [DW-1:0]   app_wdf_data,
  output logic [DW/8-1:0] app_wdf_mask,
  output logic            app_wdf_wren,
  output logic            app_wdf_end,
  input  logic            app_wdf_rdy,
  input  logic [DW-1:0]   app_rd_data,
  input  logic            app_rd_data_end,
  input  logic            app_rd_data_valid,
  output logic            req_rnext,
  input  logic            req_rqempty,
  input  logic [31:0]     req_qraddr,
  input  logic            req_rd_bwt,
  input  logic [LW-1:0]   req_len,
  output logic            wdq_rnext,
  input  logic            wdq_rqempty,
  input  logic [DW-1:0]   wdq_rdata,
  input  logic [DW/8-1:0] wdq_rmask,
  output logic            rdq_wen,
  output logic [DW-1:0]   rdq_wdata,
  input  logic [CW-1:0]   rdq_space,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   beat_reg, beat_next;
  logic [LW-1:0]   len_reg, len_next;
  logic [AW-1:0]   base_reg, base_next;
  logic            type_reg, type_next;
  logic            cmd_done_reg, cmd_done_next;
  logic            dat_done_reg, dat_done_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;

  logic rd_accept, cmd_fire, dat_fire, cmd_now, dat_now, last_beat;
  logic unused_bits;

  // The read-data end flag and upper request-address bits carry no information here.
  assign unused_bits = ^{app_rd_data_end, req_qraddr, type_reg};

  assign last_beat    = (beat_reg == len_reg);
  assign app_addr     = base_reg + AW'(beat_reg) * AW'(ADDR_STEP);
  assign app_wdf_data = wdq_rdata;
  assign app_wdf_mask = wdq_rmask;
  assign app_wdf_end  = app_wdf_wren;
  assign wdq_rnext    = dat_fire;
  assign rdq_wen      = app_rd_data_valid;
  assign rdq_wdata    = app_rd_data;
  assign busy         = ~mrst & ((state_reg != IDLE) | (outstanding_reg != '0));

  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    len_next      = len_reg;
    base_next     = base_reg;
    type_next     = type_reg;
    cmd_done_next = cmd_done_reg;
    dat_done_next = dat_done_reg;
    app_en        = 1'b0;
    app_cmd       = 3'b000;
    app_wdf_wren  = 1'b0;
    req_rnext     = 1'b0;
    rd_accept     = 1'b0;
    cmd_fire      = 1'b0;
    dat_fire      = 1'b0;
    cmd_now       = cmd_done_reg;
    dat_now       = dat_done_reg;

    case (state_reg)
      IDLE: begin
        if (!req_rqempty) begin
          req_rnext     = 1'b1;
          base_next     = req_qraddr[AW-1:0];
          len_next      = req_len;
          type_next     = req_rd_bwt;
          beat_next     = '0;
          cmd_done_next = 1'b0;
          dat_done_next = 1'b0;
          state_next    = req_rd_bwt ? RD : WR;
        end
      end
      RD: begin
        app_cmd   = 3'b001;
        // Only issue a read if the read-data queue can absorb every outstanding word.
        app_en    = (outstanding_reg < rdq_space);
        rd_accept = app_en & app_rdy;
        if (rd_accept) begin
          if (last_beat) state_next = IDLE;
          else           beat_next  = beat_reg + 1'b1;
        end
      end
      WR: begin
        app_en       = ~cmd_done_reg & (dat_done_reg | ~wdq_rqempty);
        app_wdf_wren = ~dat_done_reg & ~wdq_rqempty;
        cmd_fire     = app_en & app_rdy;
        dat_fire     = app_wdf_wren & app_wdf_rdy;
        cmd_now      = cmd_done_reg | cmd_fire;
        dat_now      = dat_done_reg | dat_fire;
        if (cmd_now && dat_now) begin
          cmd_done_next = 1'b0;
          dat_done_next = 1'b0;
          if (last_beat) state_next = IDLE;
          else           beat_next  = beat_reg + 1'b1;
        end else begin
          cmd_done_next = cmd_now;
          dat_done_next = dat_now;
        end
      end
      default: state_next = IDLE;
    endcase

    // Strobes are suppressed while reset is asserted so a burst stops immediately.
    if (mrst) begin
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      req_rnext    = 1'b0;
      rd_accept    = 1'b0;
      cmd_fire     = 1'b0;
      dat_fire     = 1'b0;
    end
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({rd_accept, app_rd_data_valid})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   if (outstanding_reg != '0) outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_reg       <= IDLE;
      beat_reg        <= '0;
      len_reg         <= '0;
      base_reg        <= '0;
      type_reg        <= 1'b0;
      cmd_done_reg    <= 1'b0;
      dat_done_reg    <= 1'b0;
      outstanding_reg <= '0;
    end else begin
      state_reg       <= state_next;
      beat_reg        <= beat_next;
      len_reg         <= len_next;
      base_reg        <= base_next;
      type_reg        <= type_next;
      cmd_done_reg    <= cmd_done_next;
      dat_done_reg    <= dat_done_next;
      outstanding_reg <= outstanding_next;
    end
  end

endmodule

// File: tb/tb_mig_burst_if.sv
// Directed checks of mig_burst_if: read/write bursts, back-pressure, address wrap, reset abort.
module tb_mig_burst_if;
  localparam int DW = 128;
  localparam int AW = 28;
  localparam int LW = 4;
  localparam int CW = 5;

  logic            mclk = 1'b0;
  logic            mrst;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en;
  logic            app_rdy;
  logic [DW-1:0]   app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;
  logic            app_wdf_wren;
  logic            app_wdf_end;
  logic            app_wdf_rdy;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_end;
  logic            app_rd_data_valid;
  logic            req_rnext;
  logic            req_rqempty;
  logic [31:0]     req_qraddr;
  logic            req_rd_bwt;
  logic [LW-1:0]   req_len;
  logic            wdq_rnext;
  logic            wdq_rqempty;
  logic [DW-1:0]   wdq_rdata;
  logic [DW/8-1:0] wdq_rmask;
  logic            rdq_wen;
  logic [DW-1:0]   rdq_wdata;
  logic [CW-1:0]   rdq_space;
  logic            busy;

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [DW-1:0] D1 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
  localparam logic [DW-1:0] D2 = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;

  always #5 mclk = ~mclk;

  mig_burst_if #(.DW(DW), .AW(AW), .LW(LW), .ADDR_STEP(8), .CW(CW)) dut (
    .mclk(mclk), .mrst(mrst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end), .app_rd_data_valid(app_rd_data_valid),
    .req_rnext(req_rnext), .req_rqempty(req_rqempty), .req_qraddr(req_qraddr),
    .req_rd_bwt(req_rd_bwt), .req_len(req_len),
    .wdq_rnext(wdq_rnext), .wdq_rqempty(wdq_rqempty), .wdq_rdata(wdq_rdata), .wdq_rmask(wdq_rmask),
    .rdq_wen(rdq_wen), .rdq_wdata(rdq_wdata), .rdq_space(rdq_space), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic drain(input int n);
    app_rd_data_valid = 1'b1;
    repeat (n) tick();
    app_rd_data_valid = 1'b0;
    #1;
  endtask

  initial begin
    mrst = 1'b1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_end = 1'b0; app_rd_data_valid = 1'b0;
    req_rqempty = 1'b1; req_qraddr = '0; req_rd_bwt = 1'b0; req_len = '0;
    wdq_rqempty = 1'b1; wdq_rdata = '0; wdq_rmask = '0;
    rdq_space = 5'd16;

    // Reset state
    tick(); tick(); #1;
    chk("rst_app_en", app_en, 0);
    chk("rst_wdf_wren", app_wdf_wren, 0);
    chk("rst_wdf_end", app_wdf_end, 0);
    chk("rst_req_rnext", req_rnext, 0);
    chk("rst_wdq_rnext", wdq_rnext, 0);
    chk("rst_busy", busy, 0);
    tick(); mrst = 1'b0; #1;
    chk("idle_busy", busy, 0);
    chk("idle_cmd", app_cmd, 3'b000);

    // Four-beat read at 0x100 with ample queue space
    req_qraddr = 32'h100; req_rd_bwt = 1'b1; req_len = 4'd3; req_rqempty = 1'b0;
    app_rdy = 1'b1; #1;
    chk("r1_rnext", req_rnext, 1);
    tick(); req_rqempty = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("r1_rnext_low", req_rnext, 0);
      chk("r1_en", app_en, 1);
      chk("r1_cmd", app_cmd, 3'b001);
      chk("r1_addr", app_addr, 28'h100 + 28'(8 * i));
      tick(); #1;
    end
    chk("r1_done_en", app_en, 0);
    chk("r1_done_cmd", app_cmd, 3'b000);
    chk("r1_busy_outst", busy, 1);
    for (int i = 0; i < 4; i++) begin
      app_rd_data_valid = 1'b1; app_rd_data = 128'hA0 + 128'(i); #1;
      chk("r1_rdq_wen", rdq_wen, 1);
      chk("r1_rdq_wdata", rdq_wdata, 128'hA0 + 128'(i));
      tick(); app_rd_data_valid = 1'b0; #1;
      chk("r1_drain_busy", busy, (i < 3) ? 1 : 0);
    end
    chk("r1_rdq_wen_low", rdq_wen, 0);

    // Eight-beat read throttled by rdq_space=2
    req_qraddr = 32'h200; req_len = 4'd7; rdq_space = 5'd2; req_rqempty = 1'b0; #1;
    chk("r2_rnext", req_rnext, 1);
    tick(); req_rqempty = 1'b1; #1;
    chk("r2_b0_en", app_en, 1); chk("r2_b0_addr", app_addr, 28'h200);
    tick(); #1;
    chk("r2_b1_en", app_en, 1); chk("r2_b1_addr", app_addr, 28'h208);
    tick(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("r2_stall_en", app_en, 0);
      chk("r2_stall_addr", app_addr, 28'h210);
      tick(); #1;
    end
    app_rd_data_valid = 1'b1; #1;
    chk("r2_a_en", app_en, 0);
    tick(); #1;
    chk("r2_b_en", app_en, 1); chk("r2_b_addr", app_addr, 28'h210);
    tick(); app_rd_data_valid = 1'b0; #1;
    chk("r2_c_en", app_en, 1); chk("r2_c_addr", app_addr, 28'h218);
    tick(); #1;
    chk("r2_d_en", app_en, 0); chk("r2_d_addr", app_addr, 28'h220);
    rdq_space = 5'd16; #1;
    for (int i = 0; i < 4; i++) begin
      chk("r2_tail_en", app_en, 1);
      chk("r2_tail_addr", app_addr, 28'h220 + 28'(8 * i));
      tick(); #1;
    end
    chk("r2_done_en", app_en, 0);
    chk("r2_done_busy", busy, 1);
    drain(6);
    chk("r2_drained_busy", busy, 0);

    // Address wrap at the top of the 28-bit space
    req_qraddr = 32'h0FFF_FFF8; req_len = 4'd1; req_rqempty = 1'b0; #1;
    chk("wrap_rnext", req_rnext, 1);
    tick(); req_rqempty = 1'b1; #1;
    chk("wrap_b0_addr", app_addr, 28'hFFFFFF8); chk("wrap_b0_en", app_en, 1);
    tick(); #1;
    chk("wrap_b1_addr", app_addr, 28'h0000000); chk("wrap_b1_en", app_en, 1);
    tick(); #1;
    chk("wrap_done_en", app_en, 0);
    drain(2);
    chk("wrap_busy", busy, 0);

    // Two-beat write with command back-pressure
    req_qraddr = 32'h400; req_rd_bwt = 1'b0; req_len = 4'd1; req_rqempty = 1'b0;
    wdq_rqempty = 1'b0; wdq_rdata = D0; wdq_rmask = 16'h00FF;
    app_wdf_rdy = 1'b1; app_rdy = 1'b0; #1;
    chk("w1_rnext", req_rnext, 1);
    chk("w1_idle_wdq_rnext", wdq_rnext, 0);
    tick(); req_rqempty = 1'b1; #1;
    chk("w1_c1_en", app_en, 1); chk("w1_c1_cmd", app_cmd, 3'b000);
    chk("w1_c1_addr", app_addr, 28'h400);
    chk("w1_c1_wren", app_wdf_wren, 1); chk("w1_c1_end", app_wdf_end, 1);
    chk("w1_c1_wdq_rnext", wdq_rnext, 1);
    chk("w1_c1_data", app_wdf_data, D0); chk("w1_c1_mask", app_wdf_mask, 16'h00FF);
    tick(); wdq_rdata = D1; wdq_rmask = 16'hF0F0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("w1_hold_en", app_en, 1); chk("w1_hold_addr", app_addr, 28'h400);
      chk("w1_hold_wren", app_wdf_wren, 0); chk("w1_hold_wdq_rnext", wdq_rnext, 0);
      tick(); #1;
    end
    app_rdy = 1'b1; #1;
    chk("w1_c4_en", app_en, 1); chk("w1_c4_addr", app_addr, 28'h400);
    chk("w1_c4_wren", app_wdf_wren, 0);
    tick(); #1;
    chk("w1_b1_addr", app_addr, 28'h408); chk("w1_b1_en", app_en, 1);
    chk("w1_b1_wren", app_wdf_wren, 1); chk("w1_b1_wdq_rnext", wdq_rnext, 1);
    chk("w1_b1_data", app_wdf_data, D1); chk("w1_b1_mask", app_wdf_mask, 16'hF0F0);
    tick(); wdq_rqempty = 1'b1; #1;
    chk("w1_done_en", app_en, 0); chk("w1_done_busy", busy, 0);

    // Write stalls on an empty data queue
    req_qraddr = 32'h500; req_len = 4'd0; req_rqempty = 1'b0; #1;
    chk("w2_rnext", req_rnext, 1);
    tick(); req_rqempty = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("w2_wait_en", app_en, 0); chk("w2_wait_wren", app_wdf_wren, 0);
      chk("w2_wait_busy", busy, 1);
      tick(); #1;
    end
    wdq_rqempty = 1'b0; wdq_rdata = D2; #1;
    chk("w2_go_en", app_en, 1); chk("w2_go_wren", app_wdf_wren, 1);
    chk("w2_go_addr", app_addr, 28'h500);
    tick(); wdq_rqempty = 1'b1; #1;
    chk("w2_done_busy", busy, 0);

    // Reset in the middle of a four-beat write, then a fresh read
    req_qraddr = 32'h600; req_len = 4'd3; req_rqempty = 1'b0; wdq_rqempty = 1'b0; #1;
    tick(); req_rqempty = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      chk("w3_addr", app_addr, 28'h600 + 28'(8 * i)); chk("w3_en", app_en, 1);
      tick(); #1;
    end
    chk("w3_b2_addr", app_addr, 28'h610);
    mrst = 1'b1; #1;
    chk("w3_rst_en", app_en, 0); chk("w3_rst_wren", app_wdf_wren, 0);
    chk("w3_rst_end", app_wdf_end, 0); chk("w3_rst_wdq_rnext", wdq_rnext, 0);
    chk("w3_rst_busy", busy, 0); chk("w3_rst_rnext", req_rnext, 0);
    tick(); mrst = 1'b0; #1;
    chk("w3_post_en", app_en, 0); chk("w3_post_wren", app_wdf_wren, 0);
    chk("w3_post_busy", busy, 0);
    wdq_rqempty = 1'b1;
    req_qraddr = 32'h700; req_rd_bwt = 1'b1; req_len = 4'd0; req_rqempty = 1'b0; #1;
    chk("w3_new_rnext", req_rnext, 1);
    tick(); req_rqempty = 1'b1; #1;
    chk("w3_new_en", app_en, 1); chk("w3_new_addr", app_addr, 28'h700);
    chk("w3_new_cmd", app_cmd, 3'b001);
    tick(); #1;
    chk("w3_new_done_en", app_en, 0);
    drain(1);
    chk("w3_new_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
